// File: rtl/chaves_conditioner_if.sv
// chaves_conditioner_if: switch conditioner bus; optional event_count under CHAVES_EVENT_COUNT_EN
interface chaves_conditioner_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] chaves_raw;
    logic [WIDTH-1:0] chaves_debounced;
    logic [WIDTH-1:0] chaves_rise;
    logic [WIDTH-1:0] chaves_fall;
    logic             change_pending;
    logic             change_ack;
`ifdef CHAVES_EVENT_COUNT_EN
    logic [15:0]      event_count;
    modport master (output chaves_raw, change_ack,
                    input chaves_debounced, chaves_rise, chaves_fall, change_pending, event_count);
    modport slave  (input chaves_raw, change_ack,
                    output chaves_debounced, chaves_rise, chaves_fall, change_pending, event_count);
`else
    modport master (output chaves_raw, change_ack,
                    input chaves_debounced, chaves_rise, chaves_fall, change_pending);
    modport slave  (input chaves_raw, change_ack,
                    output chaves_debounced, chaves_rise, chaves_fall, change_pending);
`endif
endinterface

// File: rtl/chaves_conditioner.sv
// chaves_conditioner: sync, debounce, edge pulses and sticky change flag for slide switches; CHAVES_EVENT_COUNT_EN adds event_count
module chaves_conditioner #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic                 clk_clk,
    input logic                 reset_reset,
    chaves_conditioner_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] s1, s2, deb, rise, fall;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic             pending;
    // synchronise, then accept a bit once it has differed from deb for DEBOUNCE_CYCLES evaluations
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            s1   <= '0;
            s2   <= '0;
            deb  <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            s1   <= bus.chaves_raw;
            s2   <= s1;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    cnt[i]  <= '0;
                    deb[i]  <= s2[i];
                    rise[i] <= s2[i];
                    fall[i] <= !s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
    // sticky change flag; a new pulse takes priority over an ack
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) pending <= 1'b0;
        else if (|(rise | fall)) pending <= 1'b1;
        else if (bus.change_ack) pending <= 1'b0;
    end
    assign bus.chaves_debounced = deb;
    assign bus.chaves_rise      = rise;
    assign bus.chaves_fall      = fall;
    assign bus.change_pending   = pending;
`ifdef CHAVES_EVENT_COUNT_EN
    logic [15:0] ec;
    logic [16:0] ec_sum;
    // ack clears first, then this cycle's pulse count is added
    always_comb begin
        ec_sum = {1'b0, bus.change_ack ? 16'h0 : ec};
        for (int i = 0; i < WIDTH; i++) ec_sum = ec_sum + 17'(rise[i]) + 17'(fall[i]);
    end
    // saturating event counter
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) ec <= '0;
        else ec <= ec_sum[16] ? 16'hFFFF : ec_sum[15:0];
    end
    assign bus.event_count = ec;
`endif
endmodule
